dmu_arbiter: RTL and testbench

- Shares the single data memory unit (`dmu_engine`) between two requesters: port 0 is the core load/store path, port 1 is a program/debug loader or DMA port.
- Accepts one request at a time and drives the memory strobes, address and write data.
- Waits a fixed memory latency, then returns read data with a one-cycle completion pulse.
- Sits between the core datapath/loader and `dmu_engine`. Replaces the direct read_en/write_en/addr wiring into memory.

---
 rtl/dmu_arbiter.sv | 114 +++++++++++
 tb/tb_dmu_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dmu_arbiter.sv
// dmu_arbiter: two-port request arbiter in front of dmu_engine with fixed memory latency.
// Define DMU_ARB_RR_EN for round-robin arbitration; default is fixed port-0 priority.
module dmu_arbiter #(
  parameter int WIDTH       = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_we,
  input  logic [WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0] req0_wdata,
  output logic             req0_ready,
  output logic             req0_rvalid,
  input  logic             req1_valid,
  input  logic             req1_we,
  input  logic [WIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0] req1_wdata,
  output logic             req1_ready,
  output logic             req1_rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic [WIDTH-1:0] mem_read_data,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_we, r_id, r_rvalid0, r_rvalid1, r_rd_en, r_wr_en, r_busy;
  logic [WIDTH-1:0] r_addr, r_wdata, r_rdata;
  logic             w_gnt0, w_gnt1, w_accept, w_we;
  logic [WIDTH-1:0] w_addr, w_wdata;
`ifdef DMU_ARB_RR_EN
  logic r_last;
  assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);
`else
  assign w_gnt1 = req1_valid & ~req0_valid;
`endif
  assign w_gnt0   = req0_valid & ~w_gnt1;
  // ready is gated by rst so every output reads 0 while reset is held
  assign w_accept = rst & (r_state == IDLE) & (req0_valid | req1_valid);
  assign w_we     = w_gnt1 ? req1_we : req0_we;
  assign w_addr   = w_gnt1 ? req1_addr : req0_addr;
  assign w_wdata  = w_gnt1 ? req1_wdata : req0_wdata;
  assign req0_ready     = w_accept & w_gnt0;
  assign req1_ready     = w_accept & w_gnt1;
  assign req0_rvalid    = r_rvalid0;
  assign req1_rvalid    = r_rvalid1;
  assign rdata          = r_rdata;
  assign mem_read_en    = r_rd_en;
  assign mem_write_en   = r_wr_en;
  assign mem_addr       = r_addr;
  assign mem_write_data = r_wdata;
  assign busy           = r_busy;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_id      <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
`ifdef DMU_ARB_RR_EN
      r_last    <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_state <= ISSUE;
          r_we    <= w_we;
          r_id    <= w_gnt1;
          r_addr  <= w_addr;
          r_wdata <= w_wdata;
          r_rd_en <= ~w_we;
          r_wr_en <= w_we;
          r_busy  <= 1'b1;
`ifdef DMU_ARB_RR_EN
          r_last  <= w_gnt1;
`endif
        end
        ISSUE: begin
          r_rd_en <= 1'b0;
          r_wr_en <= 1'b0;
          r_cnt   <= 4'(MEM_LATENCY);
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_rdata   <= r_we ? '0 : mem_read_data;
            r_rvalid0 <= ~r_id;
            r_rvalid1 <= r_id;
            r_state   <= RESP;
          end
        end
        RESP: begin
          r_rvalid0 <= 1'b0;
          r_rvalid1 <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmu_arbiter.sv
// tb_dmu_arbiter: directed vectors for dmu_arbiter at MEM_LATENCY 1, 3 and 4 sharing one request bus.
module tb_dmu_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic v0 = 1'b0, we0 = 1'b0, v1 = 1'b0, we1 = 1'b0;
  logic [31:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0, mv = '0;
  logic [2:0] rdy0, rdy1, rv0, rv1, ren, wen, busy;
  logic [31:0] addr [3], wdata [3], rdata [3], mrd [3];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    int cd = 0;
    always @(posedge clk) cd <= ren[g] ? L : (cd > 0 ? cd - 1 : 0);
    assign mrd[g] = (cd == 1) ? mv : 32'hBAD0BAD0;
    dmu_arbiter #(.WIDTH(32), .MEM_LATENCY(L)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
      .req0_ready(rdy0[g]), .req0_rvalid(rv0[g]),
      .req1_valid(v1), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
      .req1_ready(rdy1[g]), .req1_rvalid(rv1[g]),
      .rdata(rdata[g]), .mem_read_en(ren[g]), .mem_write_en(wen[g]),
      .mem_addr(addr[g]), .mem_write_data(wdata[g]), .mem_read_data(mrd[g]),
      .busy(busy[g])
    );
  end
  typedef struct {
    logic v0, we0;
    logic [31:0] a0, d0;
    logic v1, we1;
    logic [31:0] a1, d1, mv;
    logic [6:0] f;
    logic [31:0] ea, ew, er;
  } vec_t;
  vec_t vecs [20];
  localparam logic [31:0] DB = 32'hDEADBEEF, CF = 32'hCAFEF00D, SD = 32'h12345678, AA = 32'h55AA55AA;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  initial begin
    int exp_o [4];
`ifdef DMU_ARB_RR_EN
    exp_o = '{0, 1, 0, 1};
`else
    exp_o = '{0, 0, 0, 0};
`endif
    vecs[0]  = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b0000000, 32'h00, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b1000000, 32'h00, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b0000101, 32'h10, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, DB,    7'b0000001, 32'h10, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b0010001, 32'h10, 32'h0, DB};
    vecs[5]  = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b0000000, 32'h10, 32'h0, DB};
    vecs[6]  = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h20, SD,    32'h0, 7'b0100000, 32'h10, 32'h0, DB};
    vecs[7]  = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b0000011, 32'h20, SD,    DB};
    vecs[8]  = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b0000001, 32'h20, SD,    DB};
    vecs[9]  = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b0001001, 32'h20, SD,    32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b0000000, 32'h20, SD,    32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 32'h40, AA,    32'h0, 7'b1000000, 32'h20, SD,    32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h40, AA,    32'h0, 7'b0000101, 32'h30, 32'h0, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h40, AA,    CF,    7'b0000001, 32'h30, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h40, AA,    32'h0, 7'b0010001, 32'h30, 32'h0, CF};
    vecs[15] = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h40, AA,    32'h0, 7'b0100000, 32'h30, 32'h0, CF};
    vecs[16] = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b0000011, 32'h40, AA,    CF};
    vecs[17] = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b0000001, 32'h40, AA,    CF};
    vecs[18] = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b0001001, 32'h40, AA,    32'h0};
    vecs[19] = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 7'b0000000, 32'h40, AA,    32'h0};
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      {v0, we0, a0, d0, v1, we1, a1, d1, mv} = {vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
        vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1, vecs[i].mv};
      #1;
      chk($sformatf("vec%0d", i),
        {rdy0[0], rdy1[0], rv0[0], rv1[0], ren[0], wen[0], busy[0], addr[0], wdata[0], rdata[0]},
        {vecs[i].f, vecs[i].ea, vecs[i].ew, vecs[i].er});
    end
    @(negedge clk);
    {v0, we0, a0, v1, we1, a1} = {1'b1, 1'b0, 32'h50, 1'b1, 1'b0, 32'h60};
    for (int n = 0; n < 4; n++) begin
      int w;
      w = -1;
      for (int c = 0; c < 10 && w < 0; c++) begin
        if (n > 0 || c > 0) @(negedge clk);
        #1;
        w = (rdy0[0] && rdy1[0]) ? 2 : rdy0[0] ? 0 : rdy1[0] ? 1 : -1;
      end
      chk($sformatf("grant%0d", n), 128'(w), 128'(exp_o[n]));
    end
    @(negedge clk);
    {v0, v1} = 2'b00;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    {v0, we0, a0} = {1'b1, 1'b0, 32'h44};
    mv = 32'hA5A50004;
    #1;
    chk("lat4_ready", 128'(rdy0[2]), 128'(1));
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      v0 = 1'b0;
      #1;
      chk($sformatf("lat4_k%0d", k), {busy[2], rv0[2]}, {k <= 6, k == 6});
      if (k == 6) chk("lat4_rdata", rdata[2], 32'hA5A50004);
    end
    @(negedge clk);
    {v0, we0, a0} = {1'b1, 1'b0, 32'h33};
    #1;
    chk("lat3_ready", 128'(rdy0[1]), 128'(1));
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
    #1;
    v0 = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst_zero", {rdy0[1], rdy1[1], rv0[1], rv1[1], ren[1], wen[1], busy[1], addr[1], wdata[1], rdata[1]}, '0);
    @(negedge clk);
    v0 = 1'b0;
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d", k), {rv0[1], busy[1]}, 2'b00);
    end
    @(negedge clk);
    {v0, we0, a0} = {1'b1, 1'b0, 32'h77};
    mv = 32'h12121212;
    #1;
    chk("reissue_ready", 128'(rdy0[1]), 128'(1));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      v0 = 1'b0;
      #1;
      chk($sformatf("reissue_k%0d", k), 128'(rv0[1]), 128'(k == 5));
      if (k == 5) chk("reissue_rdata", {addr[1], rdata[1]}, {32'h77, 32'h12121212});
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
